// File: rtl/btn_conditioner.sv
// Board-pin input conditioner. Buttons and switches pass through a two-flop synchroniser.
// Each button is then debounced on its own and produces a level, a press pulse and a release pulse.
module btn_conditioner #(
    parameter int N_BTN           = 5,
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                CLK,
    input  logic                reset_n,
    input  logic [N_BTN-1:0]    BTN,
    input  logic [SW_WIDTH-1:0] SW,
    output logic [N_BTN-1:0]    btn_level,
    output logic [N_BTN-1:0]    btn_press,
    output logic [N_BTN-1:0]    btn_release,
    output logic [SW_WIDTH-1:0] sw_sync
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0]    r_btn_s1;
    logic [N_BTN-1:0]    r_btn_s2;
    logic [SW_WIDTH-1:0] r_sw_s1;
    logic [SW_WIDTH-1:0] r_sw_s2;

    logic [N_BTN-1:0]    w_level;
    logic [N_BTN-1:0]    w_press;
    logic [N_BTN-1:0]    w_release;

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_btn_s1 <= BTN;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= SW;
            r_sw_s2  <= r_sw_s1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi = gi + 1) begin : g_debounce
            logic             r_level;
            logic             r_press;
            logic             r_release;
            logic [CNT_W-1:0] r_cnt;

            // A sample matching the current level discards any partial count, so bounces restart the wait.
            always_ff @(posedge CLK) begin
                if (!reset_n) begin
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    if (r_btn_s2[gi] == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_level   <= r_btn_s2[gi];
                        r_cnt     <= '0;
                        r_press   <= r_btn_s2[gi];
                        r_release <= ~r_btn_s2[gi];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_level[gi]   = r_level;
            assign w_press[gi]   = r_press;
            assign w_release[gi] = r_release;
        end
    endgenerate

    assign btn_level   = w_level;
    assign btn_press   = w_press;
    assign btn_release = w_release;
    assign sw_sync     = r_sw_s2;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed-vector bench for btn_conditioner: a per-cycle table on a D=4 instance,
// plus a hand-written reset-mid-count sequence on a D=8 instance.
module tb_btn_conditioner;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic [4:0]  BTN;
    logic [15:0] SW;

    logic [4:0]  lvl4, prs4, rel4;
    logic [15:0] sw4;
    logic [4:0]  lvl8, prs8, rel8;
    logic [15:0] sw8;

    always #5 CLK = ~CLK;

    btn_conditioner #(.N_BTN(5), .SW_WIDTH(16), .DEBOUNCE_CYCLES(4)) dut4 (
        .CLK(CLK), .reset_n(reset_n), .BTN(BTN), .SW(SW),
        .btn_level(lvl4), .btn_press(prs4), .btn_release(rel4), .sw_sync(sw4)
    );

    btn_conditioner #(.N_BTN(5), .SW_WIDTH(16), .DEBOUNCE_CYCLES(8)) dut8 (
        .CLK(CLK), .reset_n(reset_n), .BTN(BTN), .SW(SW),
        .btn_level(lvl8), .btn_press(prs8), .btn_release(rel8), .sw_sync(sw8)
    );

    typedef struct {
        logic        rst_n;
        logic [4:0]  btn;
        logic [15:0] sw;
        logic [4:0]  lvl;
        logic [4:0]  prs;
        logic [4:0]  rel;
        logic [15:0] swx;
    } vec_t;

    vec_t vecs[$];
    int   errors   = 0;
    int   n_checks = 0;

    task automatic add(input int n, input logic rst_n, input logic [4:0] btn, input logic [15:0] sw,
                       input logic [4:0] lvl, input logic [4:0] prs, input logic [4:0] rel,
                       input logic [15:0] swx);
        vec_t v;
        v.rst_n = rst_n; v.btn = btn; v.sw = sw;
        v.lvl = lvl; v.prs = prs; v.rel = rel; v.swx = swx;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic bounce [8];
        bounce = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset with everything held high, then acceptance D+1 edges after release.
        add(3, 0, 5'h1F, 16'hFFFF, 5'h00, 5'h00, 5'h00, 16'h0000);
        add(1, 1, 5'h1F, 16'hFFFF, 5'h00, 5'h00, 5'h00, 16'h0000);
        add(4, 1, 5'h1F, 16'hFFFF, 5'h00, 5'h00, 5'h00, 16'hFFFF);
        add(1, 1, 5'h1F, 16'hFFFF, 5'h1F, 5'h1F, 5'h00, 16'hFFFF);
        add(1, 1, 5'h1F, 16'hFFFF, 5'h1F, 5'h00, 5'h00, 16'hFFFF);
        add(1, 1, 5'h00, 16'h0000, 5'h1F, 5'h00, 5'h00, 16'hFFFF);
        add(4, 1, 5'h00, 16'h0000, 5'h1F, 5'h00, 5'h00, 16'h0000);
        add(1, 1, 5'h00, 16'h0000, 5'h00, 5'h00, 5'h1F, 16'h0000);
        add(1, 1, 5'h00, 16'h0000, 5'h00, 5'h00, 5'h00, 16'h0000);
        // Clean press/release of BTN[1], with the switch change landing on the same edge.
        add(1, 1, 5'h02, 16'hA5C3, 5'h00, 5'h00, 5'h00, 16'h0000);
        add(4, 1, 5'h02, 16'hA5C3, 5'h00, 5'h00, 5'h00, 16'hA5C3);
        add(1, 1, 5'h02, 16'hA5C3, 5'h02, 5'h02, 5'h00, 16'hA5C3);
        add(1, 1, 5'h02, 16'hA5C3, 5'h02, 5'h00, 5'h00, 16'hA5C3);
        add(5, 1, 5'h00, 16'hA5C3, 5'h02, 5'h00, 5'h00, 16'hA5C3);
        add(1, 1, 5'h00, 16'hA5C3, 5'h00, 5'h00, 5'h02, 16'hA5C3);
        add(1, 1, 5'h00, 16'hA5C3, 5'h00, 5'h00, 5'h00, 16'hA5C3);
        // Bounce on BTN[0]: three-sample runs never reach four, so no change.
        for (int j = 0; j < 8; j++)
            add(1, 1, {4'b0, bounce[j]}, 16'hA5C3, 5'h00, 5'h00, 5'h00, 16'hA5C3);
        add(5, 1, 5'h01, 16'hA5C3, 5'h00, 5'h00, 5'h00, 16'hA5C3);
        add(1, 1, 5'h01, 16'hA5C3, 5'h01, 5'h01, 5'h00, 16'hA5C3);
        add(1, 1, 5'h01, 16'hA5C3, 5'h01, 5'h00, 5'h00, 16'hA5C3);
        add(5, 1, 5'h00, 16'hA5C3, 5'h01, 5'h00, 5'h00, 16'hA5C3);
        add(1, 1, 5'h00, 16'hA5C3, 5'h00, 5'h00, 5'h01, 16'hA5C3);
        add(1, 1, 5'h00, 16'hA5C3, 5'h00, 5'h00, 5'h00, 16'hA5C3);
        // Independent buttons: 0 and 4 together, 2 two cycles later.
        add(2, 1, 5'h11, 16'hA5C3, 5'h00, 5'h00, 5'h00, 16'hA5C3);
        add(3, 1, 5'h15, 16'hA5C3, 5'h00, 5'h00, 5'h00, 16'hA5C3);
        add(1, 1, 5'h15, 16'hA5C3, 5'h11, 5'h11, 5'h00, 16'hA5C3);
        add(1, 1, 5'h15, 16'hA5C3, 5'h11, 5'h00, 5'h00, 16'hA5C3);
        add(1, 1, 5'h15, 16'hA5C3, 5'h15, 5'h04, 5'h00, 16'hA5C3);
        add(1, 1, 5'h15, 16'hA5C3, 5'h15, 5'h00, 5'h00, 16'hA5C3);

        foreach (vecs[i]) begin
            reset_n = vecs[i].rst_n;
            BTN     = vecs[i].btn;
            SW      = vecs[i].sw;
            tick();
            $display("vec %0d rst_n=%b btn=%h sw=%h -> level=%h press=%h release=%h sw_sync=%h",
                     i, vecs[i].rst_n, vecs[i].btn, vecs[i].sw, lvl4, prs4, rel4, sw4);
            chk("level",   i, {11'b0, lvl4}, {11'b0, vecs[i].lvl});
            chk("press",   i, {11'b0, prs4}, {11'b0, vecs[i].prs});
            chk("release", i, {11'b0, rel4}, {11'b0, vecs[i].rel});
            chk("sw_sync", i, sw4, vecs[i].swx);
        end

        // Reset mid-count on the D=8 instance: BTN[3] held, reset hits when the count is 5.
        reset_n = 1'b0; BTN = 5'h00; SW = 16'h0000;
        tick(); tick();
        reset_n = 1'b1; BTN = 5'h08;
        tick();
        repeat (6) tick();
        reset_n = 1'b0;
        tick();
        $display("mid-count reset applied: level=%h press=%h", lvl8, prs8);
        chk("d8_reset_level", 0, {11'b0, lvl8}, 16'h0000);
        chk("d8_reset_press", 0, {11'b0, prs8}, 16'h0000);
        reset_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            $display("post-reset edge %0d: level=%h press=%h", k, lvl8, prs8);
            chk("d8_wait_press", k, {11'b0, prs8}, 16'h0000);
            chk("d8_wait_level", k, {11'b0, lvl8}, 16'h0000);
        end
        tick();
        $display("post-reset edge 10: level=%h press=%h", lvl8, prs8);
        chk("d8_press", 10, {11'b0, prs8}, 16'h0008);
        chk("d8_level", 10, {11'b0, lvl8}, 16'h0008);
        tick();
        $display("post-reset edge 11: level=%h press=%h", lvl8, prs8);
        chk("d8_press_clear", 11, {11'b0, prs8}, 16'h0000);
        chk("d8_level_hold",  11, {11'b0, lvl8}, 16'h0008);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Input-conditioning stage between the board pins and `fpga_top`'s instruction-entry logic. It synchronises the asynchronous push-buttons and slide switches into the `CLK` domain, debounces each button independently, and produces a stable level plus single-cycle press and release pulses per button. Downstream logic uses `btn_press` directly for half-select toggling, latching and reset, with no edge detection of its own.

## Interface
Parameters:
- `N_BTN`, 5, number of buttons conditioned.
- `SW_WIDTH`, 16, number of slide switches synchronised.
- `DEBOUNCE_CYCLES`, 1000000, consecutive synchronised cycles a new button value must hold before it is accepted (10 ms at 100 MHz); legal range ≥ 2.

Ports:
- `CLK`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset; one clock, synchronous reset active-low.
- `BTN`  in  N_BTN  raw asynchronous buttons, 1 = pressed.
- `SW`  in  SW_WIDTH  raw asynchronous switches.
- `btn_level`  out  N_BTN  debounced button state.
- `btn_press`  out  N_BTN  one-cycle pulse on each accepted 0→1 transition of `btn_level`.
- `btn_release`  out  N_BTN  one-cycle pulse on each accepted 1→0 transition of `btn_level`.
- `sw_sync`  out  SW_WIDTH  switches after a 2-flop synchroniser; not debounced.

## Operation
- Synchroniser: each `BTN` and `SW` bit passes through two flops (`s1`, then `s2`). `sw_sync` is the `s2` stage.
- Per-button debounce runs independently on each bit `i`. Its state is `level[i]` plus a counter `cnt[i]` of width `$clog2(DEBOUNCE_CYCLES)`. Each edge:
  - If `s2[i] == level[i]`: set `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: set `level[i] <= s2[i]` and `cnt[i] <= 0`. Pulse `btn_press[i]` if the new level is 1, otherwise pulse `btn_release[i]`.
  - Else: set `cnt[i] <= cnt[i] + 1`.
- Equivalent per-button states:
  - STABLE_LO (`level=0`, `cnt=0`).
  - WAIT_HI (`level=0`, `cnt>0`).
  - STABLE_HI.
  - WAIT_LO.
  - A bounce back to the current level in WAIT returns the button to STABLE and discards the partial count.
- Pulse outputs are registered. They are 1 only in the single cycle following the edge on which `level` flips, and they are cleared on every other edge.
- `btn_press[i]` and `btn_release[i]` are never both 1. Different buttons may pulse in the same cycle.
- The counter never wraps. It is bounded by the `DEBOUNCE_CYCLES-1` compare.

## Timing
- Reset (`reset_n` = 0 at an edge) clears to 0: `s1`, `s2`, `btn_level`, `btn_press`, `btn_release`, `sw_sync`, and all counters.
  - Reset asserted mid-count abandons the count.
  - After reset the outputs behave as if all buttons had been released; a button held through reset is accepted D+1 edges after release of reset, producing a normal `btn_press`.
- Let D = `DEBOUNCE_CYCLES` and E0 = the first edge at which a new `BTN[i]` value is sampled into `s1` and held.
  - `s2` takes the value at E0+1.
  - `level` flips at edge E0+D+1; the pulse is high in the cycle after E0+D+1.
  - Latency from E0 to flip is D+1 edges.
- Glitch rejection: a raw change that persists for fewer than D consecutive `s2` cycles produces no level change and no pulse.
- `sw_sync` latency is 2 edges, with no filtering.

## Test plan
- **Reset values:** D=4. Hold `reset_n`=0 for 3 cycles with `BTN`=5'b11111 and `SW`=16'hFFFF → all outputs 0 during reset. `sw_sync`=16'hFFFF 2 edges after reset release. `btn_level`=5'b11111 and `btn_press`=5'b11111 for one cycle after edge E0+5 (E0 = first post-reset edge).
- **Clean press/release:** D=4, `BTN[1]` rises at E0 and holds 20 cycles → `btn_press`=5'b00010 for exactly one cycle after edge E0+5, and `btn_level[1]`=1 from then on. Drop `BTN[1]` → `btn_release[1]` pulses once, 5 edges after the first low sample.
- **Bounce rejection:** D=4, `BTN[0]` toggles 1,1,1,0,1,1,1,0 per cycle → `btn_level[0]` stays 0 and no pulses occur. `BTN[0]` then held high for 4+ cycles → exactly one `btn_press[0]`.
- **Independent buttons:** D=4, `BTN[0]` and `BTN[4]` rise on the same edge → both press bits pulse in the same cycle (5'b10001). `BTN[2]` rising 2 cycles later → its pulse arrives 2 cycles after theirs.
- **Reset mid-count:** D=8, `BTN[3]` held high. Assert `reset_n`=0 for one edge at count 5 → no pulse at the original deadline. `btn_press[3]` pulses 9 edges after the first post-reset sample.
- **Switch path:** `SW` changes from 16'h0000 to 16'hA5C3 at edge E0 → `sw_sync`=16'hA5C3 after E0+1, with no intermediate value.
